// File: rtl/store_buffer_if.sv
// Execute-stage / datamem bundle for the store buffer.
// The slave modport is the buffer itself; the master modport is the core and datamem side.
interface store_buffer_if;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_type;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [1:0]  ld_type;
  logic        ld_sign_ext;
  logic        ld_stall;
  logic [31:0] ld_rdata;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [1:0]  mem_type;
  logic        mem_sign_ext;
  logic [31:0] mem_dout;
  logic        sb_empty;

  modport slave (
    input  st_valid, st_addr, st_data, st_type,
    input  ld_valid, ld_addr, ld_type, ld_sign_ext,
    input  mem_dout,
    output st_ready, ld_stall, ld_rdata,
    output mem_write_en, mem_addr, mem_din, mem_type, mem_sign_ext,
    output sb_empty
  );

  modport master (
    output st_valid, st_addr, st_data, st_type,
    output ld_valid, ld_addr, ld_type, ld_sign_ext,
    output mem_dout,
    input  st_ready, ld_stall, ld_rdata,
    input  mem_write_en, mem_addr, mem_din, mem_type, mem_sign_ext,
    input  sb_empty
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store FIFO in front of the single-port datamem; loads overlapping a pending store stall.
// Define STORE_FWD_EN to let an exact addr/type match on the youngest overlapping store forward.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           rst_n,
  store_buffer_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  function automatic logic [32:0] size_m1(input logic [1:0] t);
    logic [32:0] r;
    case (t)
      2'b00:   r = 33'd0;
      2'b01:   r = 33'd1;
      default: r = 33'd3;
    endcase
    return r;
  endfunction

  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [1:0]    type_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [DEPTH-1:0] ovl_s;
  logic [32:0]      ld_lo_s, ld_hi_s;
  logic             any_ovl_s;
  logic             full_s, empty_s;
  logic             enq_s, drain_s, stall_s;
  logic             st_ready_s;
  logic             fwd_hit_s;
  logic [31:0]      fwd_data_s;

  assign full_s     = (count_q == FULL_CNT);
  assign empty_s    = (count_q == {CW{1'b0}});
  assign st_ready_s = rst_n & ~full_s;
  assign enq_s      = bus.st_valid & st_ready_s & (bus.st_type != 2'b11);
  assign any_ovl_s  = |ovl_s;

  // Byte-range intersection of the load against every live entry, in 33 bits so nothing wraps.
  always_comb begin
    ovl_s   = {DEPTH{1'b0}};
    ld_lo_s = {1'b0, bus.ld_addr};
    ld_hi_s = ld_lo_s + size_m1(bus.ld_type);
    for (int i = 0; i < DEPTH; i++) begin
      ovl_s[i] = ({1'b0, PW'(i) - head_q} < count_q)
               && ({1'b0, addr_q[i]} <= ld_hi_s)
               && (ld_lo_s <= ({1'b0, addr_q[i]} + size_m1(type_q[i])));
    end
  end

`ifdef STORE_FWD_EN
  function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] t, input logic s);
    logic [31:0] r;
    case (t)
      2'b00:   r = {{24{s & d[7]}}, d[7:0]};
      2'b01:   r = {{16{s & d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  logic [PW-1:0] yng_idx_s;
  logic          yng_found_s;

  // Walk oldest to youngest; the last overlapping entry is the one the load must observe.
  always_comb begin
    yng_idx_s   = head_q;
    yng_found_s = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      yng_idx_s   = ovl_s[head_q + PW'(k)] ? (head_q + PW'(k)) : yng_idx_s;
      yng_found_s = yng_found_s | ovl_s[head_q + PW'(k)];
    end
    fwd_hit_s  = yng_found_s
               && (addr_q[yng_idx_s] == bus.ld_addr)
               && (type_q[yng_idx_s] == bus.ld_type);
    fwd_data_s = extend(data_q[yng_idx_s], bus.ld_type, bus.ld_sign_ext);
  end
`else
  assign fwd_hit_s  = 1'b0;
  assign fwd_data_s = 32'h0000_0000;
`endif

  // Port arbitration: a full buffer always drains; otherwise a clean load owns the port.
  always_comb begin
    drain_s = 1'b0;
    stall_s = 1'b0;
    if (!rst_n) begin
      stall_s = 1'b1;
    end else if (full_s) begin
      drain_s = 1'b1;
      stall_s = bus.ld_valid;
    end else if (bus.ld_valid && !any_ovl_s) begin
      drain_s = 1'b0;
    end else if (bus.ld_valid && fwd_hit_s) begin
      drain_s = ~empty_s;
    end else begin
      stall_s = bus.ld_valid;
      drain_s = ~empty_s;
    end
  end

  // Datamem port and load result.
  always_comb begin
    bus.st_ready     = st_ready_s;
    bus.sb_empty     = empty_s;
    bus.ld_stall     = stall_s;
    bus.ld_rdata     = fwd_hit_s ? fwd_data_s : bus.mem_dout;
    bus.mem_write_en = drain_s;
    bus.mem_sign_ext = bus.ld_sign_ext;
    if (drain_s) begin
      bus.mem_addr = addr_q[head_q];
      bus.mem_din  = data_q[head_q];
      bus.mem_type = type_q[head_q];
    end else begin
      bus.mem_addr = bus.ld_addr;
      bus.mem_din  = 32'h0000_0000;
      bus.mem_type = bus.ld_type;
    end
  end

  // Pointer and occupancy next state; pointers wrap naturally at DEPTH.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain_s) begin
      head_d = head_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      head_d = head_q;
    end
    if (enq_s) begin
      tail_d = tail_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      tail_d = tail_q;
    end
    if (enq_s && !drain_s) begin
      count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
    end else if (drain_s && !enq_s) begin
      count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload; contents of free slots are never observed so they carry no reset.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      addr_q[tail_q] <= bus.st_addr;
      data_q[tail_q] <= bus.st_data;
      type_q[tail_q] <= bus.st_type;
    end
  end
endmodule
